sine_core_arbiter: RTL and testbench

- Shares one sine-calculator core (start/ready handshake, x operand in, result out) among NREQ requesters.
- Arbitration is round-robin. The block sequences the core's start pulse, holds the operand stable for the whole computation, captures the result and returns it to the granted requester with a one-cycle ack.
- Sits between the requester-side logic and the single core instance.

---
 rtl/sine_core_arbiter.sv | 159 +++++++++++++++
 tb/tb_sine_core_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_core_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sine_core_arbiter_lane
//   Per-requester ack decode. One instance per requester; asserts its ack bit
//   only while the arbiter is delivering to that requester's index.
//   deliver : arbiter is in its one-cycle delivery state
//   gid     : index of the requester currently being served
//   ack     : this requester's ack bit
// -----------------------------------------------------------------------------
module sine_core_arbiter_lane #(
    parameter int IDX = 0,
    parameter int GW  = 2
) (
    input  logic          deliver,
    input  logic [GW-1:0] gid,
    output logic          ack
);
    assign ack = deliver && (gid == GW'(IDX));
endmodule

// -----------------------------------------------------------------------------
// sine_core_arbiter
//   Shares a single sine core among NREQ requesters with round-robin
//   arbitration. Sequences the core start pulse, holds the operand for the
//   whole computation, re-issues start if the core never acknowledges it, and
//   returns the captured result with a one-cycle ack to the served requester.
//
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   req         : per-requester request level (held with operand until ack)
//   x_in        : packed operands, slice k = x_in[k*W +: W]
//   ack         : one-cycle pulse to the served requester, result valid then
//   result      : registered result of the last completed operation
//   busy        : high in every state except IDLE
//   core_start  : start pulse to the core
//   core_x      : registered operand to the core
//   core_ready  : core idle/done flag (high = idle)
//   core_result : core output, valid while core_ready is high after completion
// -----------------------------------------------------------------------------
module sine_core_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int TMO  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] x_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic              core_start,
    output logic [W-1:0]      core_x,
    input  logic              core_ready,
    input  logic [W-1:0]      core_result
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DELIVER   = 3'd4;

    logic [2:0]               state;
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            gid;
    logic [PW-1:0]            gid_next;
    logic [PW-1:0]            pick;
    logic                     found;
    logic [PW:0]              scan;
    logic [TW-1:0]            tmo_cnt;
    logic                     deliver;
    logic [NREQ-1:0][W-1:0]   x_arr;

    // Operand slices and per-requester ack lanes.
    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        assign x_arr[k] = x_in[k*W +: W];
        sine_core_arbiter_lane #(
            .IDX (k),
            .GW  (PW)
        ) u_lane (
            .deliver (deliver),
            .gid     (gid),
            .ack     (ack[k])
        );
    end

    // Round-robin scan starting at ptr. ptr < NREQ, so ptr+i < 2*NREQ and a
    // single conditional subtract gives the wrap for any NREQ, power of 2 or not.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(NREQ))
                scan = scan - (PW+1)'(NREQ);
            if (!found && req[scan[PW-1:0]]) begin
                found = 1'b1;
                pick  = scan[PW-1:0];
            end
        end
    end

    assign gid_next   = (gid == PW'(NREQ-1)) ? '0 : gid + PW'(1);
    assign deliver    = (state == S_DELIVER);
    assign core_start = (state == S_START);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gid     <= '0;
            core_x  <= '0;
            result  <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // core_x is loaded only here, so it stays put for the
                    // whole operation, including any start re-issue.
                    if (core_ready && found) begin
                        gid    <= pick;
                        core_x <= x_arr[pick];
                        state  <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Core never dropped ready: assume the start was missed
                    // and pulse it again with the same operand.
                    if (!core_ready)
                        state <= S_WAIT_DONE;
                    else if (tmo_cnt == TW'(TMO-1))
                        state <= S_START;
                    else
                        tmo_cnt <= tmo_cnt + TW'(1);
                end
                S_WAIT_DONE: begin
                    if (core_ready) begin
                        result <= core_result;
                        state  <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    ptr   <= gid_next;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sine_core_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sine_core_arbiter
//   Randomized scoreboard bench. Requesters are fed from per-requester operand
//   lists; a round-robin reference model predicts the service order and the
//   result of each operation; a monitor pops predictions as acks appear.
//   A behavioural core model answers start pulses with a random busy time.
// -----------------------------------------------------------------------------
module tb_sine_core_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 8;
    localparam int DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] x_in = '0;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic              busy;
    logic              core_start;
    logic [W-1:0]      core_x;
    logic              core_ready = 1'b0;
    logic [W-1:0]      core_result = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sine_core_arbiter #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .x_in        (x_in),
        .ack         (ack),
        .result      (result),
        .busy        (busy),
        .core_start  (core_start),
        .core_x      (core_x),
        .core_ready  (core_ready),
        .core_result (core_result)
    );

    typedef struct {
        int         k;
        logic [W-1:0] op;
        logic [W-1:0] res;
        int         starts;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] pend_op[NREQ][DEPTH];
    int           pend_wr[NREQ] = '{default: 0};
    int           pend_rd[NREQ] = '{default: 0};
    int           mrd[NREQ]     = '{default: 0};
    int           ptr_m = 0;
    logic [NREQ-1:0] drop = '0;

    bit           hold_low = 1'b1;
    int           fix_lat  = 0;
    bit           ovr_en   = 1'b0;
    logic [W-1:0] ovr_val  = '0;
    int           ign_arm  = 0;
    int           cyc      = 0;
    int           start_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in sine function for the core model.
    function automatic logic [W-1:0] res_of(input logic [W-1:0] x);
        if (ovr_en) return ovr_val;
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    // ---------------- core model ----------------
    initial begin
        int cnt;
        int ign_seen;
        logic [W-1:0] cur_x;
        cnt = 0; ign_seen = 0; cur_x = '0;
        forever begin
            @(negedge clk);
            if (rst || hold_low) begin
                core_ready = !hold_low;
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_ready  = 1'b1;
                    core_result = res_of(cur_x);
                end
            end else begin
                core_ready = 1'b1;
                if (core_start) begin
                    if (ign_arm != ign_seen) begin
                        ign_seen = ign_arm;     // drop this start on the floor
                    end else begin
                        cur_x       = core_x;
                        core_ready  = 1'b0;
                        core_result = W'($urandom);
                        cnt = (fix_lat > 0) ? fix_lat : $urandom_range(2, 8);
                    end
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++)
                if (ack[k]) pend_rd[k]++;
            for (int k = 0; k < NREQ; k++) begin
                if (pend_rd[k] < pend_wr[k] && !drop[k]) begin
                    req[k] = 1'b1;
                    x_in[k*W +: W] = pend_op[k][pend_rd[k]];
                end else begin
                    req[k] = 1'b0;
                    x_in[k*W +: W] = W'($urandom);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int nstart;
        int last_start;
        exp_t e;
        logic [NREQ-1:0] oh;
        nstart = 0; last_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                nstart = 0;
                continue;
            end
            if (busy && exp_q.size() > 0)
                chk("core_x_stable", core_x, exp_q[0].op);
            if (core_start) begin
                start_total++;
                nstart++;
                chk("busy_at_start", busy, 1);
                if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
                if (nstart == 2) chk("tmo_spacing", cyc - last_start, TMO + 1);
                last_start = cyc;
            end
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.k] = 1'b1;
                    chk("ack_grant", ack, oh);
                    chk("result", result, e.res);
                    chk("busy_at_ack", busy, 1);
                    chk("start_count", nstart, e.starts);
                end
                nstart = 0;
            end
        end
    end

    // ---------------- reference model + stimulus helpers ----------------
    task automatic add_op(input int k, input logic [W-1:0] op);
        pend_op[k][pend_wr[k]] = op;
        pend_wr[k]++;
    endtask

    // Round-robin service of everything loaded since the last call: the next
    // requester served is the first one at or after ptr_m with work left.
    task automatic run_model(input bit ign);
        exp_t e;
        bit   first;
        bit   any;
        first = 1'b1;
        do begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (ptr_m + i) % NREQ;
                if (!any && mrd[k] < pend_wr[k]) begin
                    any = 1'b1;
                    e.k = k;
                    e.op = pend_op[k][mrd[k]];
                    e.res = res_of(e.op);
                    e.starts = (first && ign) ? 2 : 1;
                    exp_q.push_back(e);
                    mrd[k]++;
                    ptr_m = (k + 1) % NREQ;
                    first = 1'b0;
                end
            end
        end while (any);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_core_busy(input int max);
        int n;
        n = 0;
        while (core_ready && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("core_went_busy", core_ready, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_x"}, core_x, 0);
        chk({tag, "_result"}, result, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Core not ready at power-up: nothing may start until it is.
        add_op(1, W'($urandom));
        run_model(1'b0);
        repeat (12) @(negedge clk);
        chk("no_start_not_ready", start_total, 0);
        chk("idle_not_ready", busy, 0);
        hold_low = 1'b0;
        drain(200);

        // Single request, fixed core latency and result.
        fix_lat = 10; ovr_en = 1'b1; ovr_val = 16'hABCD;
        add_op(0, 16'h1234);
        run_model(1'b0);
        drain(200);
        fix_lat = 0; ovr_en = 1'b0;

        // Serve 3, then 0101 must go 0 then 2 (pointer wrap and skip).
        add_op(3, W'($urandom)); run_model(1'b0); drain(200);
        add_op(0, W'($urandom)); add_op(2, W'($urandom)); run_model(1'b0); drain(400);
        add_op(3, W'($urandom)); run_model(1'b0); drain(200);

        // All four requesting with back-to-back re-requests: 0,1,2,3,0,1.
        for (int k = 0; k < NREQ; k++) begin
            add_op(k, W'($urandom));
            if (k < 2) add_op(k, W'($urandom));
        end
        run_model(1'b0);
        drain(1000);

        // Start timeout: first start ignored, reissued after TMO cycles.
        ign_arm++;
        add_op(2, W'($urandom));
        run_model(1'b1);
        drain(400);

        // Random batches, occasionally with an ignored first start.
        for (int it = 0; it < 20; it++) begin
            int tot;
            bit ign;
            tot = 0;
            for (int k = 0; k < NREQ; k++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) add_op(k, W'($urandom));
                tot += n;
            end
            ign = (tot > 0) && ($urandom_range(0, 3) == 0);
            if (ign) ign_arm++;
            run_model(ign);
            drain(3000);
        end

        // Requester 1 withdraws (and scrambles its operand) mid-operation.
        fix_lat = 6;
        add_op(1, W'($urandom));
        run_model(1'b0);
        wait_core_busy(50);
        @(negedge clk);
        drop[1] = 1'b1;
        drain(200);
        drop[1] = 1'b0;
        fix_lat = 0;

        // Reset mid-operation: leave ptr at 3, then reset during WAIT_DONE.
        add_op(2, W'($urandom)); run_model(1'b0); drain(200);
        fix_lat = 20;
        add_op(3, W'($urandom));
        run_model(1'b0);
        wait_core_busy(50);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("midop_reset");
        exp_q.delete();
        for (int k = 0; k < NREQ; k++) begin
            pend_rd[k] = pend_wr[k];
            mrd[k] = pend_wr[k];
        end
        ptr_m = 0;
        fix_lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // ptr back at 0: requester 1 first, then 3.
        add_op(1, W'($urandom)); add_op(3, W'($urandom));
        run_model(1'b0);
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
